// File: rtl/cpu_pkg.sv
// Shared CPU execute-stage definitions: shift direction codes, FSM states, latency.
package cpu_pkg;

    localparam int SHAMT_WIDTH_DEF = 5;
    localparam int SHIFT_LATENCY   = SHAMT_WIDTH_DEF;

    localparam logic DIR_SLL = 1'b0;
    localparam logic DIR_SRA = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_t;

endpackage

// File: rtl/shift_stage_bidir.sv
// One fixed-distance shift stage: SLL zero-fills, SRA fills with the supplied sign bit.
module shift_stage_bidir
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIST       = 1
) (
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  enable,
    input  logic                  dir,
    input  logic                  fill,
    output logic [DATA_WIDTH-1:0] out
);

    always_comb begin
        out = in;
        if (enable) begin
            if (dir == DIR_SRA) begin
                out = {{DIST{fill}}, in[DATA_WIDTH-1:DIST]};
            end else begin
                out = {in[DATA_WIDTH-1-DIST:0], {DIST{1'b0}}};
            end
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multicycle SLL/SRA shifter: one power-of-two stage per clock (16,8,4,2,1), start/ready handshake.
module shift_unit_seq
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ctrl_start,
    input  logic                   ctrl_dir,
    input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
    input  logic [DATA_WIDTH-1:0]  data_operandA,
    output logic [DATA_WIDTH-1:0]  data_result,
    output logic                   data_resultRDY,
    output logic                   busy
);

    localparam int CNT_W = $clog2(SHAMT_WIDTH + 1);

    shift_state_t           state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_WIDTH-1:0]  work;
    logic [SHAMT_WIDTH-1:0] shamt_q;
    logic                   dir_q;
    logic                   sign_q;
    logic                   cnt_last;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  stage_out [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0]  sel_out;

    // Stage k handles distance 2^(SHAMT_WIDTH-1-k), gated by the matching shamt bit.
    for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
        shift_stage_bidir #(
            .DATA_WIDTH(DATA_WIDTH),
            .DIST      (1 << (SHAMT_WIDTH - 1 - k))
        ) u_stage (
            .in    (work),
            .enable(shamt_q[SHAMT_WIDTH-1-k]),
            .dir   (dir_q),
            .fill  (sign_q),
            .out   (stage_out[k])
        );
    end

    assign sel_out  = stage_out[cnt];
    assign cnt_last = (cnt == CNT_W'(SHAMT_WIDTH - 1));
    assign accept   = (state == ST_IDLE) && ctrl_start;
    assign busy     = (state == ST_SHIFT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ctrl_start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt_last)   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            work           <= '0;
            shamt_q        <= '0;
            dir_q          <= DIR_SLL;
            sign_q         <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (accept) begin
                work    <= data_operandA;
                shamt_q <= ctrl_shiftamt;
                dir_q   <= ctrl_dir;
                sign_q  <= data_operandA[DATA_WIDTH-1];
                cnt     <= '0;
            end else if (state == ST_SHIFT) begin
                work <= sel_out;
                cnt  <= cnt + 1'b1;
                if (cnt_last) begin
                    data_result    <= sel_out;
                    data_resultRDY <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq against an arithmetic shift model.
module tb_shift_unit_seq;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_start = 1'b0;
    logic        ctrl_dir = 1'b0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // The RDY pulse is seen on the (latency+1)th falling edge after the accepting edge.
    localparam int EXP_CYC = SHIFT_LATENCY + 1;

    shift_unit_seq dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_start    (ctrl_start),
        .ctrl_dir      (ctrl_dir),
        .ctrl_shiftamt (ctrl_shiftamt),
        .data_operandA (data_operandA),
        .data_result   (data_result),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [31:0] a, input logic dir, input int sh);
        logic signed [31:0] s;
        s = a;
        if (dir) return s >>> sh;
        return a << sh;
    endfunction

    // Drive a request for the next rising edge; inputs are scrambled after acceptance.
    task automatic launch(input logic [31:0] a, input logic dir, input logic [4:0] sh);
        ctrl_start    = 1'b1;
        ctrl_dir      = dir;
        ctrl_shiftamt = sh;
        data_operandA = a;
        @(posedge clock);
        #1;
        ctrl_start    = 1'b0;
        ctrl_dir      = 1'($urandom);
        ctrl_shiftamt = 5'($urandom);
        data_operandA = $urandom;
    endtask

    task automatic wait_done(output int cyc, output logic [31:0] res,
                             output int busy_err, output int hold_err);
        logic [31:0] old;
        old      = data_result;
        cyc      = -1;
        res      = 'x;
        busy_err = 0;
        hold_err = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                cyc = i;
                res = data_result;
                if (busy) busy_err++;
                return;
            end
            if (!busy) busy_err++;
            if (data_result !== old) hold_err++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (data_result !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_during: result=%h rdy=%b busy=%b required 0/0/0",
                     data_result, data_resultRDY, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (data_result !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: result=%h rdy=%b busy=%b required 0/0/0",
                     data_result, data_resultRDY, busy);
        end
    endtask

    task automatic test_directed();
        logic [31:0] a_t  [7] = '{32'h1, 32'h80000000, 32'h7FFFFFF0, 32'h12345678,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        logic        d_t  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int          s_t  [7] = '{31, 4, 2, 0, 16, 31, 1};
        logic [31:0] e_t  [7] = '{32'h80000000, 32'hF8000000, 32'h1FFFFFFC, 32'h12345678,
                                  32'hFFFF0000, 32'hFFFFFFFF, 32'h00000002};
        int cyc, be, he;
        logic [31:0] res;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            launch(a_t[i], d_t[i], 5'(s_t[i]));
            wait_done(cyc, res, be, he);
            n_checks++;
            if (cyc != EXP_CYC || res !== e_t[i] || be != 0 || he != 0) begin
                n_fail++;
                $display("FAIL directed_%0d: cyc=%0d result=%h busy_err=%0d hold_err=%0d required cyc=%0d result=%h",
                         i, cyc, res, be, he, EXP_CYC, e_t[i]);
            end
            @(negedge clock);
            n_checks++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== e_t[i]) begin
                n_fail++;
                $display("FAIL directed_pulse_%0d: rdy=%b busy=%b result=%h required 0/0/%h",
                         i, data_resultRDY, busy, data_result, e_t[i]);
            end
        end
    endtask

    task automatic test_random();
        int cyc, be, he, sh, idle;
        logic [31:0] a, res, exp;
        logic dir;
        for (int i = 0; i < 40; i++) begin
            a    = $urandom;
            dir  = 1'($urandom);
            sh   = $urandom_range(0, 31);
            exp  = model(a, dir, sh);
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) @(negedge clock);
            @(negedge clock);
            launch(a, dir, 5'(sh));
            wait_done(cyc, res, be, he);
            n_checks++;
            if (cyc != EXP_CYC || res !== exp || be != 0 || he != 0) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h dir=%b sh=%0d cyc=%0d result=%h be=%0d he=%0d required cyc=%0d result=%h",
                         i, a, dir, sh, cyc, res, be, he, EXP_CYC, exp);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int rdy_n = 0, rdy_at = -1;
        logic [31:0] res = 'x;
        @(negedge clock);
        launch(32'h1, DIR_SLL, 5'd3);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                rdy_n++;
                rdy_at = i;
                res    = data_result;
            end
            if (i == 2) launch(32'h80000000, DIR_SRA, 5'd1);
        end
        n_checks++;
        if (rdy_n != 1 || rdy_at != EXP_CYC || res !== 32'h00000008 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy: rdy_count=%0d rdy_at=%0d result=%h busy=%b required 1/%0d/00000008/0",
                     rdy_n, rdy_at, res, busy, EXP_CYC);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, be, he;
        logic [31:0] res, first;
        first = model(32'h12345678, DIR_SLL, 4);
        @(negedge clock);
        launch(32'h12345678, DIR_SLL, 5'd4);
        wait_done(cyc, res, be, he);
        n_checks++;
        if (cyc != EXP_CYC || res !== first) begin
            n_fail++;
            $display("FAIL b2b_first: cyc=%0d result=%h required %0d/%h", cyc, res, EXP_CYC, first);
        end
        launch(32'h3, DIR_SLL, 5'd1);
        n_checks++;
        if (busy !== 1'b1 || data_result !== first) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b result=%h required 1/%h", busy, data_result, first);
        end
        wait_done(cyc, res, be, he);
        n_checks++;
        if (cyc != EXP_CYC || res !== 32'h6 || be != 0 || he != 0) begin
            n_fail++;
            $display("FAIL b2b_second: cyc=%0d result=%h busy_err=%0d hold_err=%0d required %0d/00000006/0/0",
                     cyc, res, be, he, EXP_CYC);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc, be, he, stray = 0;
        logic [31:0] res;
        @(negedge clock);
        launch(32'h0000FFFF, DIR_SLL, 5'd8);
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (data_result !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op: result=%h rdy=%b busy=%b required 0/0/0",
                     data_result, data_resultRDY, busy);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (data_resultRDY || busy || data_result !== 32'h0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL reset_no_rdy: stray_cycles=%0d required 0", stray);
        end
        @(negedge clock);
        launch(32'h1, DIR_SLL, 5'd1);
        wait_done(cyc, res, be, he);
        n_checks++;
        if (cyc != EXP_CYC || res !== 32'h2 || be != 0) begin
            n_fail++;
            $display("FAIL reset_recover: cyc=%0d result=%h busy_err=%0d required %0d/00000002/0",
                     cyc, res, be, EXP_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
